// File: rtl/day_counter.sv
// ---------------------------------------------------------------------------
// day_counter
//
// Day-of-month counter for a calendar clock. It advances on the hour
// counter's midnight carry and sends a one-cycle carry to the month counter
// when the month rolls over. The month length comes from month_bin and
// year_bin using the full Gregorian leap rules. When the day field is
// selected, the up/down buttons step the day manually. A held button steps
// the day only once.
//
// Ports:
//   clk_1Hz        in   system clock; all state changes on the rising edge
//   rst_n          in   synchronous active-low reset
//   en_1           in   count enable for carry-driven advance
//   up / down      in   button levels; rising edges are detected internally
//   select_item    in   adjust-field selector (SELECT_DAY = adjust this block)
//   carry_in       in   one-cycle pulse from the hour counter at 23->00
//   month_bin      in   current month 1..12 from the month counter
//   year_bin       in   current year, binary
//   day_bin        out  current day 1..31 (registered)
//   carry_out      out  one-cycle pulse to the month counter (registered)
//   days_in_month  out  length of the current month (combinational)
//   leap_year      out  leap flag for year_bin (combinational)
// ---------------------------------------------------------------------------
module day_counter #(
  parameter logic [2:0] SELECT_DAY = 3'b011,
  parameter int         YEAR_W     = 14
) (
  input  logic              clk_1Hz,
  input  logic              rst_n,
  input  logic              en_1,
  input  logic              up,
  input  logic              down,
  input  logic [2:0]        select_item,
  input  logic              carry_in,
  input  logic [3:0]        month_bin,
  input  logic [YEAR_W-1:0] year_bin,
  output logic [4:0]        day_bin,
  output logic              carry_out,
  output logic [4:0]        days_in_month,
  output logic              leap_year
);

  logic up_q;
  logic down_q;
  logic up_p;
  logic down_p;
  logic adjust_mode;
  logic div_by_4;
  logic div_by_100;
  logic div_by_400;

  // Gregorian leap rule. Year 0 is divisible by 400, so it counts as leap.
  assign div_by_4   = (year_bin[1:0] == 2'b00);
  assign div_by_100 = ((year_bin % YEAR_W'(100)) == '0);
  assign div_by_400 = ((year_bin % YEAR_W'(400)) == '0);
  assign leap_year  = div_by_4 && (!div_by_100 || div_by_400);

  // Month length. An out-of-range month gets the longest length, so a
  // corrupted month never forces the day down.
  always_comb begin
    days_in_month = 5'd31;
    case (month_bin)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap_year ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  end

  assign up_p        = up & ~up_q;
  assign down_p      = down & ~down_q;
  assign adjust_mode = (select_item == SELECT_DAY);

  // Day state. Manual adjust has priority over carry counting. Neither
  // adjusting nor clamping ever produces a month carry. The final branch
  // pulls the day back into range one cycle after the month or year shrinks.
  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      day_bin   <= 5'd1;
      carry_out <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      up_q      <= up;
      down_q    <= down;
      carry_out <= 1'b0;
      if (adjust_mode) begin
        if (up_p && down_p) begin
          day_bin <= day_bin;
        end else if (up_p) begin
          day_bin <= (day_bin >= days_in_month) ? 5'd1 : day_bin + 5'd1;
        end else if (down_p) begin
          day_bin <= (day_bin <= 5'd1 || day_bin > days_in_month) ?
                     days_in_month : day_bin - 5'd1;
        end else if (day_bin > days_in_month) begin
          day_bin <= days_in_month;
        end
      end else if (en_1 && carry_in) begin
        if (day_bin >= days_in_month) begin
          day_bin   <= 5'd1;
          carry_out <= 1'b1;
        end else begin
          day_bin <= day_bin + 5'd1;
        end
      end else if (day_bin > days_in_month) begin
        day_bin <= days_in_month;
      end
    end
  end

endmodule

// File: tb/tb_day_counter.sv
// ---------------------------------------------------------------------------
// tb_day_counter
//
// Testbench for day_counter. A calendar reference model works in plain
// integers: it keeps the current day and the last button levels, and it
// derives month lengths from a table plus the leap-year arithmetic. The
// bench runs directed calendar scenarios first, then a randomized run.
// It compares every DUT output with the model after every clock edge.
// ---------------------------------------------------------------------------
module tb_day_counter;

  localparam logic [2:0] SEL = 3'b011;

  logic        clk_1Hz = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_1 = 1'b0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic [2:0]  select_item = 3'b000;
  logic        carry_in = 1'b0;
  logic [3:0]  month_bin = 4'd1;
  logic [13:0] year_bin = 14'd2000;
  logic [4:0]  day_bin;
  logic        carry_out;
  logic [4:0]  days_in_month;
  logic        leap_year;

  int checks = 0;
  int failures = 0;

  // Calendar reference state.
  int m_day = 1;
  int m_carry = 0;
  bit m_up = 1'b0;
  bit m_down = 1'b0;

  day_counter #(.SELECT_DAY(SEL), .YEAR_W(14)) dut (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .en_1(en_1), .up(up), .down(down),
    .select_item(select_item), .carry_in(carry_in), .month_bin(month_bin),
    .year_bin(year_bin), .day_bin(day_bin), .carry_out(carry_out),
    .days_in_month(days_in_month), .leap_year(leap_year)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  function automatic bit ref_leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int ref_dim(int m, int y);
    int lens [12];
    lens = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2) return ref_leap(y) ? 29 : 28;
    return lens[m-1];
  endfunction

  // Advance the calendar model by one clock edge with the given inputs.
  task automatic modelEdge(input bit r, e, u, d, input int s, c, m, y);
    int dim;
    bit up_edge;
    bit down_edge;
    dim = ref_dim(m, y);
    if (!r) begin
      m_day = 1; m_carry = 0; m_up = 0; m_down = 0;
    end else begin
      up_edge   = u && !m_up;
      down_edge = d && !m_down;
      m_up = u; m_down = d; m_carry = 0;
      if (s == SEL) begin
        if (up_edge && !down_edge) m_day = (m_day >= dim) ? 1 : m_day + 1;
        else if (down_edge && !up_edge) m_day = (m_day <= 1 || m_day > dim) ? dim : m_day - 1;
        else if (!(up_edge && down_edge) && m_day > dim) m_day = dim;
      end else if (e && c) begin
        if (m_day >= dim) begin m_day = 1; m_carry = 1; end
        else m_day = m_day + 1;
      end else if (m_day > dim) begin
        m_day = dim;
      end
    end
  endtask

  // Compare all DUT outputs with the model.
  task automatic checkOutput(input string tag);
    checks++;
    assert (int'(day_bin) === m_day) else begin
      failures++;
      $error("[TB] FAIL %s day_bin got=%0d exp=%0d", tag, day_bin, m_day);
    end
    checks++;
    assert (int'(carry_out) === m_carry) else begin
      failures++;
      $error("[TB] FAIL %s carry_out got=%0d exp=%0d", tag, carry_out, m_carry);
    end
    checks++;
    assert (int'(days_in_month) === ref_dim(month_bin, year_bin)) else begin
      failures++;
      $error("[TB] FAIL %s days_in_month got=%0d exp=%0d", tag, days_in_month,
             ref_dim(month_bin, year_bin));
    end
    checks++;
    assert (leap_year === ref_leap(year_bin)) else begin
      failures++;
      $error("[TB] FAIL %s leap_year got=%0d exp=%0d", tag, leap_year, ref_leap(year_bin));
    end
  endtask

  // Hand-computed calendar checkpoints from the scenario descriptions.
  task automatic checkConst(input string tag, input int exp_day, input int exp_carry);
    checks++;
    assert (int'(day_bin) === exp_day && int'(carry_out) === exp_carry) else begin
      failures++;
      $error("[TB] FAIL %s got day=%0d carry=%0d exp day=%0d carry=%0d",
             tag, day_bin, carry_out, exp_day, exp_carry);
    end
  endtask

  // Drive one cycle of inputs on the falling edge. Optionally glitch rst_n
  // low between edges. Let one rising edge pass, then check.
  task automatic applyStimulus(input bit r, e, u, d, input logic [2:0] s,
                               input bit c, input logic [3:0] m,
                               input logic [13:0] y, input bit glitch,
                               input string tag);
    @(negedge clk_1Hz);
    rst_n = r; en_1 = e; up = u; down = d; select_item = s;
    carry_in = c; month_bin = m; year_bin = y;
    if (glitch) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
    end
    @(posedge clk_1Hz);
    modelEdge(r, e, u, d, int'(s), int'(c), int'(m), int'(y));
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [13:0] yr;
    // Reset with arbitrary inputs.
    applyStimulus(0, 1, 1, 0, SEL, 1, 4'd7, 14'd1234, 0, "reset0");
    applyStimulus(0, 0, 0, 1, 3'd0, 1, 4'd2, 14'd99, 0, "reset1");
    checkConst("reset_state", 1, 0);

    // Move to day 31 in January, then glitch reset between edges.
    applyStimulus(1, 0, 0, 1, SEL, 0, 4'd1, 14'd2024, 0, "adj_to31");
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 4'd1, 14'd2024, 1, "rst_glitch");
    checkConst("rst_glitch_hold", 31, 0);

    // Leap February 2024.
    applyStimulus(1, 1, 0, 0, SEL, 0, 4'd2, 14'd2024, 0, "feb_clamp29");
    applyStimulus(1, 1, 0, 1, SEL, 0, 4'd2, 14'd2024, 0, "feb_down28");
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd2, 14'd2024, 0, "feb_release");
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 4'd2, 14'd2024, 0, "leap_28to29");
    checkConst("leap_day29", 29, 0);
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 4'd2, 14'd2024, 0, "leap_roll");
    checkConst("leap_rollover", 1, 1);
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd2, 14'd2024, 0, "leap_after");
    checkConst("carry_one_cycle", 1, 0);

    // Century year 1900 is not leap.
    applyStimulus(1, 1, 0, 1, SEL, 0, 4'd2, 14'd1900, 0, "y1900_to28");
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd2, 14'd1900, 0, "y1900_rel");
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 4'd2, 14'd1900, 0, "y1900_carry");
    checkConst("y1900_roll", 1, 1);

    // Year 2000 is leap.
    applyStimulus(1, 1, 0, 1, SEL, 0, 4'd2, 14'd2000, 0, "y2000_to29");
    applyStimulus(1, 1, 0, 0, SEL, 0, 4'd2, 14'd2000, 0, "y2000_rel");
    applyStimulus(1, 1, 0, 1, SEL, 0, 4'd2, 14'd2000, 0, "y2000_to28");
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd2, 14'd2000, 0, "y2000_rel2");
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 4'd2, 14'd2000, 0, "y2000_carry");
    checkConst("y2000_day29", 29, 0);

    // Year 2100 is not leap. Day 29 clamps to 28, then rolls over.
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd2, 14'd2100, 0, "y2100_clamp");
    checkConst("y2100_clamp28", 28, 0);
    applyStimulus(1, 1, 0, 0, 3'd0, 1, 4'd2, 14'd2100, 0, "y2100_carry");
    checkConst("y2100_roll", 1, 1);

    // Manual adjust in April. Held down steps once, and carries are ignored.
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1, 0, 1, SEL, (i % 2 == 0), 4'd4, 14'd2023, 0, "adj_hold_down");
    checkConst("adj_down_once", 30, 0);
    applyStimulus(1, 1, 0, 0, SEL, 1, 4'd4, 14'd2023, 0, "adj_release");
    applyStimulus(1, 1, 1, 0, SEL, 1, 4'd4, 14'd2023, 0, "adj_up");
    checkConst("adj_up_wrap", 1, 0);
    applyStimulus(1, 1, 0, 0, SEL, 0, 4'd4, 14'd2023, 0, "adj_up_rel");

    // Clamp from day 31 in January to February 2023, then to March.
    applyStimulus(1, 1, 0, 0, SEL, 0, 4'd1, 14'd2023, 0, "clamp_m1");
    applyStimulus(1, 1, 0, 1, SEL, 0, 4'd1, 14'd2023, 0, "clamp_to31");
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd1, 14'd2023, 0, "clamp_rel");
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd2, 14'd2023, 0, "clamp_feb");
    checkConst("clamp_28", 28, 0);
    applyStimulus(1, 1, 0, 0, 3'd0, 0, 4'd3, 14'd2023, 0, "clamp_mar");
    checkConst("clamp_stay28", 28, 0);

    // Gating. Step up to day 31 in December, then a carry with en_1=0.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, SEL, 0, 4'd12, 14'd2023, 0, "gate_up");
      applyStimulus(1, 1, 0, 0, SEL, 0, 4'd12, 14'd2023, 0, "gate_uprel");
    end
    applyStimulus(1, 0, 0, 0, 3'd0, 1, 4'd12, 14'd2023, 0, "gate_en0");
    checkConst("gate_hold31", 31, 0);
    applyStimulus(1, 0, 1, 1, SEL, 0, 4'd12, 14'd2023, 0, "both_edges");
    checkConst("both_hold", 31, 0);
    applyStimulus(1, 0, 0, 0, 3'd0, 0, 4'd12, 14'd2023, 0, "both_rel");

    // Randomized run against the calendar model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0: yr = 14'd1900;
        1: yr = 14'd2000;
        2: yr = 14'd0;
        3: yr = 14'd2100;
        default: yr = 14'($urandom_range(0, 9999));
      endcase
      applyStimulus(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
                    1'($urandom),
                    ($urandom_range(0, 2) == 0) ? SEL : 3'($urandom),
                    ($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 12)),
                    yr, 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/day_counter.md
Name: day_counter

Overview:
- Day-of-month counter that feeds the month counter. It is the producer of the month counter's carry_in and consumer of its month_bin.
- Advances on the hour-rollover carry and emits a one-cycle carry_out when the month ends.
- Computes days-in-month from month_bin and year_bin, with full Gregorian leap rules.
- Supports manual up/down adjustment when the day field is selected, using synchronous edge detection.

Parameters:
- SELECT_DAY, 3'b011, select_item code that puts this block in manual-adjust mode.
- YEAR_W, 14, width of year_bin (covers years 0..9999).

Ports:
- clk_1Hz  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk_1Hz.
- en_1  input  1  count enable for carry-driven advance.
- up  input  1  increment button level; rising edge detected internally.
- down  input  1  decrement button level; rising edge detected internally.
- select_item  input  3  adjust-field selector.
- carry_in  input  1  one-cycle pulse from the hour counter at 23→00.
- month_bin  input  4  current month, 1..12, from the month counter.
- year_bin  input  YEAR_W  current year, binary.
- day_bin  output  5  current day, 1..31.
- carry_out  output  1  one-cycle pulse to the month counter's carry_in.
- days_in_month  output  5  combinational length of the current month.
- leap_year  output  1  combinational leap flag for year_bin.

Behaviour:
- Reset (rst_n==0 at a clock edge): day_bin=1, carry_out=0, up_q=0, down_q=0. rst_n has no effect between clock edges.
- Leap year: leap_year = (year%4==0) && ((year%100!=0) || (year%400==0)). Year 0 counts as leap.
- Days in month:
  - Months 4, 6, 9, 11 → 30.
  - Month 2 → 29 if leap_year, else 28.
  - Months 1, 3, 5, 7, 8, 10, 12 → 31.
  - Invalid month (0, 13..15) → 31.
- Edge detect:
  - up_q and down_q register the previous up/down levels.
  - up_p = up & ~up_q; down_p = down & ~down_q.
  - A held button produces exactly one step.
- Per-cycle priority (first matching row wins):
  1. Adjust mode (select_item==SELECT_DAY):
     - up_p && down_p → hold.
     - up_p → day_bin = (day_bin >= dim) ? 1 : day_bin+1.
     - down_p → day_bin = (day_bin <= 1 || day_bin > dim) ? dim : day_bin-1.
     - No pulse → clamp rule.
     - carry_in is ignored in this mode and carry_out=0. Adjusting never carries into the month.
     - en_1 does not gate adjustment.
  2. Count (en_1 && carry_in, not in adjust mode):
     - day_bin >= dim → day_bin=1, carry_out=1.
     - Otherwise day_bin+1, carry_out=0.
  3. Clamp (otherwise): if day_bin > dim, day_bin=dim; else hold.
- carry_out:
  - Registered; it is 0 in every cycle except the cycle following a count-rollover edge.
  - Never high for two consecutive cycles, because carry_in is a single-cycle pulse.
- Clamp latency: one cycle after month_bin or year_bin changes (e.g. 31 → 30, 31 → 28). Clamping never raises carry_out.
- day_bin never holds 0 and never exceeds 31. After the clamp cycle, day_bin <= dim.
- Latency: day_bin and carry_out update on the same edge that samples carry_in.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with arbitrary inputs → day_bin=1, carry_out=0. A rst_n low glitch between edges → no change.
- Leap February:
  - Year 2024, month 2, day 28, carry_in pulse, en_1=1 → day 29, carry_out=0.
  - Next carry_in → day 1, carry_out=1 for exactly one cycle.
- Century rules, month 2, day 28, one carry_in each:
  - Year 1900 → day 1 with carry_out=1.
  - Year 2000 → day 29 with no carry.
  - Year 2100 → day 1 with carry.
- Manual adjust:
  - select_item=SELECT_DAY, month 4, day 1, down held high 5 cycles → day 30 after one step only.
  - Release, then pulse up → day 1.
  - carry_in pulses during this period → day unchanged, carry_out=0.
- Clamp: day 31, month 1; switch month_bin to 2, year 2023 → next cycle day 28, carry_out=0. Switch month_bin to 3 → day stays 28.
- Gating: en_1=0, day 31, month 12, carry_in pulse → day 31, carry_out=0. Simultaneous up and down edges in adjust mode → day unchanged.
